// File: rtl/bf8b_mem_pkg.sv
// Shared definitions for the unified byte memory arbiter: FSM state
// encoding, port identifiers and the wait-state counter width.
package bf8b_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous byte RAM with a registered read. No reset:
// contents survive a controller reset.
module mem_array #(
  parameter int M_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [M_WIDTH-1:0] addr,
  input  logic [M_WIDTH-1:0] wdata,
  output logic [M_WIDTH-1:0] rdata
);

  logic [M_WIDTH-1:0] r_mem [2**M_WIDTH];

  // Write when enabled; read port is registered every cycle.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter in front of a unified single-port byte memory, serving a fetch
// port (I, read-only) and a load/store port (D). Accesses are serialised
// and padded with WAIT_STATES cycles between grant and access.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- ties alternate between
// ports using a last-winner flag; otherwise D always wins a tie.
//
//   state | meaning
//   IDLE  | waiting for a request; grant and latch request fields
//   BUSY  | counting wait states; access the array when count is zero
//   ACK   | one-cycle ready pulse to the granted port
module mem_arbiter #(
  parameter int M_WIDTH     = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [M_WIDTH-1:0] i_addr,
  output logic [M_WIDTH-1:0] i_data,
  output logic               i_ready,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [M_WIDTH-1:0] d_addr,
  input  logic [M_WIDTH-1:0] d_wdata,
  output logic [M_WIDTH-1:0] d_rdata,
  output logic               d_ready,
  output logic               busy
);
  import bf8b_mem_pkg::*;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_gnt, r_we;
  logic [M_WIDTH-1:0] r_addr, r_wdata;
  logic [M_WIDTH-1:0] r_i_data, r_d_rdata;
  logic [M_WIDTH-1:0] w_rdata;
  logic               w_grant, w_access, w_winner, w_mem_we;
  logic               w_ack_i, w_ack_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Pick the winner: on a tie, the port that did not win the last grant.
  always_comb begin
    w_winner = PORT_I;
    if (i_req && d_req) w_winner = ~r_last;
    else if (d_req)     w_winner = PORT_D;
  end

  // Remember who won the most recent grant (contested or not).
  always_ff @(posedge clk) begin
    if (!rst)         r_last <= PORT_I;
    else if (w_grant) r_last <= w_winner;
  end
`else
  // Pick the winner: fixed priority, D beats I.
  always_comb begin
    w_winner = PORT_I;
    if (d_req) w_winner = PORT_D;
  end
`endif

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          w_grant     = 1'b1;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the winning request at grant; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_gnt   <= w_winner;
      r_wdata <= d_wdata;
      if (w_winner == PORT_D) begin
        r_addr <= d_addr;
        r_we   <= d_we;
      end else begin
        r_addr <= i_addr;
        r_we   <= 1'b0;
      end
    end
  end

  // A write is blocked if reset arrives on the access edge.
  assign w_mem_we = w_access && r_we && rst;

  mem_array #(.M_WIDTH(M_WIDTH)) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (r_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  assign w_ack_i = (r_state == ST_ACK) && (r_gnt == PORT_I);
  assign w_ack_d = (r_state == ST_ACK) && (r_gnt == PORT_D);

  // Hold each port's last read byte; updated as the ACK cycle ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_data  <= '0;
      r_d_rdata <= '0;
    end else if (r_state == ST_ACK && !r_we) begin
      if (r_gnt == PORT_I) r_i_data  <= w_rdata;
      else                 r_d_rdata <= w_rdata;
    end
  end

  // During ACK the freshly registered array byte is presented directly.
  assign i_data  = w_ack_i ? w_rdata : r_i_data;
  assign d_rdata = (w_ack_d && !r_we) ? w_rdata : r_d_rdata;
  assign i_ready = w_ack_i;
  assign d_ready = w_ack_d;
  assign busy    = (r_state == ST_BUSY) || (r_state == ST_ACK);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level model that
// predicts service order, ready timing, busy windows and read data.
module tb_mem_arbiter;

  localparam int WS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req, d_req, d_we;
  logic [7:0] i_addr, d_addr, d_wdata;
  logic [7:0] i_data, d_rdata;
  logic       i_ready, d_ready, busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [256];
  logic [7:0] exp_i, exp_d;
  bit         last_d;

  mem_arbiter #(.M_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration episode: raise the selected requests together in an
  // IDLE cycle and check every cycle until both are served.
  task automatic run(input bit ri, input logic [7:0] ia, input bit rd, input bit we,
                     input logic [7:0] da, input logic [7:0] wd, input bit scr, input bit drop);
    bit         two, d_first, eb;
    int         f, s, c_i, c_d, c_end;
    logic [7:0] ei, ed;
    two = ri && rd;
    if (two) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_first = !last_d;
`else
      d_first = 1'b1;
`endif
    end else begin
      d_first = rd;
    end
    f     = WS + 2;
    s     = f + WS + 3;
    c_d   = rd ? (d_first ? f : s) : -1;
    c_i   = ri ? (d_first ? s : f) : -1;
    if (!two) c_i = ri ? f : -1;
    c_end = two ? s : f;
    ei = exp_i;
    ed = exp_d;
    if (d_first) begin
      if (we) mem_m[da] = wd; else ed = mem_m[da];
      if (ri) ei = mem_m[ia];
    end else begin
      if (ri) ei = mem_m[ia];
      if (rd) begin
        if (we) mem_m[da] = wd; else ed = mem_m[da];
      end
    end
    last_d = two ? !d_first : rd;

    @(negedge clk);
    i_req = ri; i_addr = ia;
    d_req = rd; d_we = we; d_addr = da; d_wdata = wd;
    for (int c = 1; c <= c_end; c++) begin
      @(posedge clk); #1;
      eb = (c <= f) || (two && c >= f + 2);
      chk("i_ready", i_ready, c == c_i);
      chk("d_ready", d_ready, c == c_d);
      chk("busy", busy, eb);
      if (c == c_i) begin chk("i_data", i_data, ei); i_req = 1'b0; end
      if (c == c_d) begin chk("d_rdata", d_rdata, ed); d_req = 1'b0; end
      if (c == 1 || (two && c == f + 2)) begin
        if (scr) begin
          if ((c == 1) == d_first) begin
            d_addr = d_addr + 8'd1; d_wdata = ~d_wdata; d_we = ~d_we;
          end else begin
            i_addr = i_addr + 8'd1;
          end
        end
        if (drop && c == 1) begin
          if (d_first) d_req = 1'b0; else i_req = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    chk("i_data_hold", i_data, ei);
    chk("d_rdata_hold", d_rdata, ed);
    chk("idle_busy", busy, 1'b0);
    exp_i = ei;
    exp_d = ed;
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    exp_i = '0; exp_d = '0; last_d = 1'b0;

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_i_data", i_data, 8'h00);
    chk("rst_d_rdata", d_rdata, 8'h00);

    // Give every byte a known value.
    for (int a = 0; a < 256; a++) run(1'b0, 8'h00, 1'b1, 1'b1, 8'(a), 8'($urandom), 1'b0, 1'b0);

    // Write then fetch the same byte.
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0);
    run(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("t2_i_data", i_data, 8'h5A);

    // Top address write does not wrap onto address zero.
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0);
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    run(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("t4_addr00", d_rdata, 8'hC3);
    run(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("t4_addrFF", d_rdata, 8'hFF);

    // Fetch address changed after grant; also req dropped early.
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 8'h55, 1'b0, 1'b0);
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 8'h66, 1'b0, 1'b0);
    run(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("t6_i_data", i_data, 8'h55);

    // Reset in the cycle after grant aborts a pending write.
    run(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h33;
    @(posedge clk); #1;
    chk("t5_busy_granted", busy, 1'b1);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    chk("t5_d_ready_a", d_ready, 1'b0);
    chk("t5_busy_a", busy, 1'b0);
    @(posedge clk); #1;
    chk("t5_d_ready_b", d_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_d_ready_c", d_ready, 1'b0);
    chk("t5_i_data", i_data, 8'h00);
    chk("t5_d_rdata", d_rdata, 8'h00);
    exp_i = '0; exp_d = '0; last_d = 1'b0;
    run(1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
    chk("t5_old_value", d_rdata, 8'h11);

    // Simultaneous requests right after reset, then a second tie.
    run(1'b1, 8'h21, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    run(1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 8'hA7, 1'b0, 1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t3_rr_i_first", i_data, 8'h5A);
`else
    chk("t3_fixed_d_first", i_data, 8'hA7);
`endif

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run(k != 1, 8'($urandom), k != 0, 1'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
